// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sequencer sharing one sequential multiplier core among NREQ requesters.
// Define MULT_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles (rsp_err, result=0).

module mult_arbiter_lane #(
    parameter int IDX = 0,
    parameter int IW  = 2
) (
    input  logic          hold,
    input  logic          resp,
    input  logic          err,
    input  logic [IW-1:0] sel,
    output logic          gnt,
    output logic          rsp_valid,
    output logic          rsp_err
);
    logic hit;

    assign hit       = (sel == IW'(IDX));
    assign gnt       = hit & hold;
    assign rsp_valid = hit & resp;
    assign rsp_err   = hit & resp & err;
endmodule

module mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   opa_flat,
    input  logic [NREQ*WIDTH-1:0]   opb_flat,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [NREQ-1:0]         rsp_err,
    output logic [2*WIDTH-1:0]      result,
    output logic                    busy,
    output logic                    mult_start,
    output logic [WIDTH-1:0]        mult_a,
    output logic [WIDTH-1:0]        mult_b,
    input  logic                    mult_done,
    input  logic [2*WIDTH-1:0]      mult_res
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } opnd_t;

    state_t               state, state_nx;
    opnd_t [NREQ-1:0]     ops;
    logic  [IW-1:0]       ptr, sel, pick, cand;
    logic  [IW:0]         sum;
    logic                 pick_ok;
    logic                 tmo;
    logic                 err_q;

    if (TIMEOUT < 2) begin : g_timeout_too_small
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign ops[i].a = opa_flat[i*WIDTH +: WIDTH];
        assign ops[i].b = opb_flat[i*WIDTH +: WIDTH];

        mult_arbiter_lane #(.IDX(i), .IW(IW)) u_lane (
            .hold      (busy),
            .resp      (state == RESP),
            .err       (err_q),
            .sel       (sel),
            .gnt       (gnt[i]),
            .rsp_valid (rsp_valid[i]),
            .rsp_err   (rsp_err[i])
        );
    end

    // Walk downward so the lowest cyclic offset from ptr wins.
    always_comb begin
        pick    = ptr;
        pick_ok = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ))
                sum = sum - (IW+1)'(NREQ);
            cand = sum[IW-1:0];
            if (req[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pick_ok) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (mult_done || tmo) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign mult_start = (state == START);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            sel    <= '0;
            mult_a <= '0;
            mult_b <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (pick_ok) begin
                    sel    <= pick;
                    mult_a <= ops[pick].a;
                    mult_b <= ops[pick].b;
                end
                WAIT: begin
                    if (mult_done) result <= mult_res;
                    else if (tmo)  result <= '0;
                end
                RESP: ptr <= (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] tcnt;

    assign tmo = (state == WAIT) && !mult_done && (tcnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == START)     tcnt <= '0;
            else if (state == WAIT) tcnt <= tcnt + 1'b1;
            if (state == WAIT && state_nx == RESP)
                err_q <= tmo;
        end
    end
`else
    assign tmo   = 1'b0;
    assign err_q = 1'b0;
`endif
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one sequential multiplier core between `NREQ` requesters, such as several SPI slave front-ends.
- Grants the core to one requester at a time and latches that requester's operands.
- Issues a single-cycle `mult_start`, waits for `mult_done`, captures the product and returns it with a per-requester valid pulse.
- Sits between the SPI front-end FSMs and the multiplier core, in the multiplier peripheral.

## Interface
- `WIDTH`, 8, operand width; product is `2*WIDTH`.
- `NREQ`, 4, number of requesters (2..8).
- `TIMEOUT`, 64, maximum WAIT-state cycles before abort (used only with `MULT_ARB_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  level request, one bit per requester.
- `opa_flat`  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `opb_flat`  in  NREQ*WIDTH  operand B; same packing as `opa_flat`.
- `gnt`  out  NREQ  one-hot; high from START through RESP for the served requester.
- `rsp_valid`  out  NREQ  one-cycle pulse on the served requester's bit.
- `rsp_err`  out  NREQ  one-cycle timeout pulse, coincident with `rsp_valid`.
- `result`  out  2*WIDTH  registered product; held until the next capture.
- `busy`  out  1  high whenever state != IDLE.
- `mult_start`  out  1  start strobe to the core.
- `mult_a`, `mult_b`  out  WIDTH  latched operands, stable from START until the return to IDLE.
- `mult_done`  in  1  completion strobe from the core.
- `mult_res`  in  2*WIDTH  product from the core; valid while `mult_done`=1.

## Operation
States are IDLE, START, WAIT and RESP (2-bit encoding).

- **IDLE**
  - If `req` != 0, select the first set bit at or after `ptr`, searching cyclically upward.
  - Latch that requester's operands into `mult_a`/`mult_b`.
  - Set `gnt` one-hot and go to START.
  - If `req` == 0, stay in IDLE.
- **START**
  - `mult_start`=1 for exactly this cycle.
  - `mult_done` is ignored here.
  - Go to WAIT unconditionally.
- **WAIT**
  - On `mult_done`=1, register `mult_res` into `result` and go to RESP.
  - Otherwise stay in WAIT.
- **RESP**
  - `rsp_valid[g]`=1, where g is the granted index.
  - `ptr` <= (g+1) mod NREQ.
  - Go to IDLE; `gnt` clears on entry to IDLE.

Behaviour rules:
- `req` is sampled only in IDLE. A requester dropping `req` mid-service does not abort the transaction; the result is still delivered.
- A requester must deassert `req` on the edge that ends its `rsp_valid` cycle; otherwise it is eligible again, behind the others by round-robin order.
- `mult_done` outside WAIT is ignored and does not alter `result`.
- Arithmetic: no width conversion; `result` = `mult_res` bit-for-bit.
- Reset (async, any state):
  - state=IDLE, `ptr`=0, `result`=0, `mult_a`=`mult_b`=0.
  - All of `gnt`, `rsp_valid`, `rsp_err`, `mult_start` and `busy` =0.
  - The multiplier core shares `rst_n`, so no stale `mult_done` survives reset.

## Timing
- Grant selected at edge n (IDLE sees `req`): START in cycle n+1 with `mult_start`=1; WAIT from n+2.
- `mult_done` in cycle m puts RESP in cycle m+1; IDLE follows in m+2.
- Minimum `req` to `rsp_valid` latency is 3 cycles plus the core latency; zero-latency core (done in first WAIT cycle) gives `req`@0 → `rsp_valid`@3.
- Back-to-back service: a new grant can be made in the IDLE cycle right after RESP, so there is one idle cycle between transactions.
- All outputs are registered or decoded from the state register only; there is no combinational path from `req` or `mult_done` to any output.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined:
  - A counter clears on START and increments each WAIT cycle.
  - When it reaches `TIMEOUT`-1 without `mult_done`, go to RESP with `result` <= 0 and `rsp_err[g]`=1 alongside `rsp_valid[g]`.
  - `ptr` advances as normal.
- Undefined:
  - No counter; WAIT holds until `mult_done`.
  - `rsp_err` is tied to 0 and the port is retained.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WAIT → all outputs 0 immediately, state IDLE; release, `req`=0 → `busy` stays 0.
- **Single request:** `req`=0001, A=3, B=5, core done after 4 cycles → one `mult_start` pulse, `result`=15, `rsp_valid`=0001 exactly once, at cycle 3+4.
- **Simultaneous requests:** `req`=1010 held from reset → grant order 1, 3, 1, 3; each `rsp_valid` matches its `gnt`.
- **Fairness:** all four `req` held, each with distinct operands → grants 0, 1, 2, 3, 0; each result equals that requester's A*B (e.g. 255*255=65025).
- **Spurious done:** `mult_done` pulsed in IDLE and START → no state change, `result` unchanged.
- **Timeout (with `MULT_ARB_TIMEOUT_EN`, TIMEOUT=8):** `mult_done` never asserted → RESP after 8 WAIT cycles, `rsp_err`=`rsp_valid`=granted bit, `result`=0; without the macro the block stays in WAIT.
